video_binarize: RTL and testbench

Pixel-stream binarization stage between the test-pattern/video source (`video_display`) and `dvi_transmitter_top` in the `pix_clk` domain. It converts the incoming 24-bit RGB888 stream to 8-bit luma and compares the luma against a threshold. It outputs pure white or pure black pixels. Sync and data-enable are delayed to stay aligned with the pixels. The threshold is either fixed (software/strap value) or adaptive: the rounded mean luma of the previous complete frame.

---
 rtl/video_binarize.sv | 164 ++++++++++++++++
 tb/tb_video_binarize.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_binarize.sv
// video_binarize
//   RGB888 pixel stream -> 8-bit luma -> black/white pixel, three register
//   stages, no stalls. The threshold is either a fixed value or the rounded
//   mean luma of the previous complete frame.
//
// Ports
//   pix_clk      pixel clock, the only clock
//   rstn         synchronous active-low reset
//   vs_in/hs_in/de_in, pixel_in   incoming timing and RGB888 (R[23:16] G[15:8] B[7:0])
//   thresh_mode  0 = fixed thresh_in, 1 = adaptive (mean of previous frame)
//   thresh_in    fixed threshold, taken at frame boundaries
//   bypass       1 = pass delayed RGB through unchanged
//   vs_out/hs_out/de_out, pixel_data   inputs delayed by 3 cycles / result pixel
//   thresh_out   threshold currently in use
module video_binarize #(
  parameter int          H_ACT          = 1920,
  parameter int          V_ACT          = 1080,
  parameter logic [31:0] RECIP          = 32'd2071,
  parameter logic [7:0]  DEFAULT_THRESH = 8'd128
) (
  input  logic        pix_clk,
  input  logic        rstn,
  input  logic        vs_in,
  input  logic        hs_in,
  input  logic        de_in,
  input  logic [23:0] pixel_in,
  input  logic        thresh_mode,
  input  logic [7:0]  thresh_in,
  input  logic        bypass,
  output logic        vs_out,
  output logic        hs_out,
  output logic        de_out,
  output logic [23:0] pixel_data,
  output logic [7:0]  thresh_out
);

  localparam logic [21:0] FRAME_PIX = 22'(H_ACT * V_ACT);

  // pipeline
  logic [15:0] sum1;
  logic [23:0] rgb1;
  logic        vs1, hs1, de1;
  logic [7:0]  gray2;
  logic [23:0] rgb2;
  logic        vs2, hs2, de2;

  // frame statistics
  logic        vs_prev;
  logic        edge_d1, edge_d2;
  logic [31:0] acc, acc_l;
  logic [21:0] cnt, cnt_l;
  logic [7:0]  mean_r;
  logic        frame_full;
  logic [7:0]  thr;

  logic [15:0] sum_c;
  logic [7:0]  gray_c;
  logic        frame_edge;
  logic [63:0] prod_c;
  logic [63:0] mean_wide;

  always_comb begin
    sum_c = 16'(pixel_in[23:16]) * 16'd77
          + 16'(pixel_in[15:8])  * 16'd150
          + 16'(pixel_in[7:0])   * 16'd29;
    gray_c     = 8'(sum1 >> 8);
    frame_edge = vs_in & ~vs_prev;
    // mean = round(acc_l / (H_ACT*V_ACT)) via fixed-point reciprocal
    prod_c     = 64'(acc_l) * 64'(RECIP);
    mean_wide  = (prod_c + 64'h0000_0000_8000_0000) >> 32;
  end

  always_ff @(posedge pix_clk) begin
    if (!rstn) begin
      sum1       <= '0;
      rgb1       <= '0;
      vs1        <= 1'b0;
      hs1        <= 1'b0;
      de1        <= 1'b0;
      gray2      <= '0;
      rgb2       <= '0;
      vs2        <= 1'b0;
      hs2        <= 1'b0;
      de2        <= 1'b0;
      vs_out     <= 1'b0;
      hs_out     <= 1'b0;
      de_out     <= 1'b0;
      pixel_data <= '0;
    end else begin
      sum1   <= sum_c;
      rgb1   <= pixel_in;
      vs1    <= vs_in;
      hs1    <= hs_in;
      de1    <= de_in;

      gray2  <= gray_c;
      rgb2   <= rgb1;
      vs2    <= vs1;
      hs2    <= hs1;
      de2    <= de1;

      vs_out <= vs2;
      hs_out <= hs2;
      de_out <= de2;
      if (!de2)
        pixel_data <= '0;
      else if (bypass)
        pixel_data <= rgb2;
      else if (gray2 >= thr)
        pixel_data <= 24'hFF_FFFF;
      else
        pixel_data <= 24'h00_0000;
    end
  end

  // Statistics count the luma as it is produced in stage 2. At a vsync
  // rising edge the running totals are snapshotted and restarted; a pixel
  // arriving in that same cycle already belongs to the new frame.
  always_ff @(posedge pix_clk) begin
    if (!rstn) begin
      vs_prev    <= 1'b0;
      edge_d1    <= 1'b0;
      edge_d2    <= 1'b0;
      acc        <= '0;
      cnt        <= '0;
      acc_l      <= '0;
      cnt_l      <= '0;
      mean_r     <= '0;
      frame_full <= 1'b0;
      thr        <= DEFAULT_THRESH;
    end else begin
      vs_prev <= vs_in;
      edge_d1 <= frame_edge;
      edge_d2 <= edge_d1;

      if (frame_edge) begin
        acc_l <= acc;
        cnt_l <= cnt;
        acc   <= de1 ? {24'd0, gray_c} : 32'd0;
        cnt   <= de1 ? 22'd1 : 22'd0;
      end else if (de1) begin
        acc <= acc + {24'd0, gray_c};
        cnt <= cnt + 22'd1;
      end

      if (edge_d1) begin
        mean_r     <= (mean_wide > 64'd255) ? 8'hFF : mean_wide[7:0];
        frame_full <= (cnt_l == FRAME_PIX);
      end

      // Only a frame with exactly the nominal pixel count may steer the
      // adaptive threshold; partial (post-reset) or oversized frames are ignored.
      if (edge_d2) begin
        if (!thresh_mode)
          thr <= thresh_in;
        else if (frame_full)
          thr <= mean_r;
      end
    end
  end

  assign thresh_out = thr;

endmodule

// File: tb/tb_video_binarize.sv
// Self-checking bench for video_binarize (small 16x8 frame).
module tb_video_binarize;

  localparam int          H_ACT = 16;
  localparam int          V_ACT = 8;
  localparam int          NPIX  = H_ACT * V_ACT;
  localparam logic [31:0] RECIP = 32'd33554432;

  logic        pix_clk = 1'b0;
  logic        rstn = 1'b0;
  logic        vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
  logic [23:0] pixel_in = '0;
  logic        thresh_mode = 1'b0;
  logic [7:0]  thresh_in = 8'd128;
  logic        bypass = 1'b0;
  logic        vs_out, hs_out, de_out;
  logic [23:0] pixel_data;
  logic [7:0]  thresh_out;

  int checks = 0;
  int errors = 0;
  int fail_prints = 0;

  always #5 pix_clk = ~pix_clk;

  video_binarize #(
    .H_ACT(H_ACT), .V_ACT(V_ACT), .RECIP(RECIP), .DEFAULT_THRESH(8'd128)
  ) dut (
    .pix_clk(pix_clk), .rstn(rstn),
    .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in), .pixel_in(pixel_in),
    .thresh_mode(thresh_mode), .thresh_in(thresh_in), .bypass(bypass),
    .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out),
    .pixel_data(pixel_data), .thresh_out(thresh_out)
  );

  function automatic int gray_of(input logic [23:0] p);
    int r, g, b;
    r = p[23:16];
    g = p[15:8];
    b = p[7:0];
    return (77 * r + 150 * g + 29 * b) / 256;
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        vs;
    logic        hs;
    logic        de;
    logic [23:0] pix;
  } smp_t;

  smp_t    hist[$];
  int      m_thr = 128;
  longint  m_sum = 0, m_cnt = 0, m_snap_sum = 0, m_snap_cnt = 0;
  int      m_upd = 0;
  bit      m_prev_vs = 1'b0;
  bit      model_on = 1'b0;
  logic        exp_vs = 1'b0, exp_hs = 1'b0, exp_de = 1'b0;
  logic [23:0] exp_pix = '0;

  initial begin
    smp_t s, old, p1;
    longint mean;
    hist.push_back('0);
    hist.push_back('0);
    forever begin
      @(posedge pix_clk);
      if (!rstn) begin
        model_on = 1'b1;
        m_thr = 128; m_sum = 0; m_cnt = 0; m_snap_sum = 0; m_snap_cnt = 0;
        m_upd = 0; m_prev_vs = 1'b0;
        hist.delete();
        hist.push_back('0);
        hist.push_back('0);
        exp_vs = 1'b0; exp_hs = 1'b0; exp_de = 1'b0; exp_pix = '0;
      end else begin
        s = '{vs: vs_in, hs: hs_in, de: de_in, pix: pixel_in};
        old = hist.pop_front();   // sampled two edges ago: leaves the pipe now
        p1  = hist[0];            // sampled one edge ago: enters the statistics now
        exp_vs = old.vs;
        exp_hs = old.hs;
        exp_de = old.de;
        if (!old.de)                      exp_pix = 24'h0;
        else if (bypass)                  exp_pix = old.pix;
        else if (gray_of(old.pix) >= m_thr) exp_pix = 24'hFFFFFF;
        else                              exp_pix = 24'h0;
        if (m_upd > 0) begin
          m_upd--;
          if (m_upd == 0) begin
            if (!thresh_mode) m_thr = thresh_in;
            else if (m_snap_cnt == NPIX) begin
              mean = (2 * m_snap_sum + NPIX) / (2 * NPIX);
              m_thr = (mean > 255) ? 255 : int'(mean);
            end
          end
        end
        if (s.vs && !m_prev_vs) begin
          m_snap_sum = m_sum;
          m_snap_cnt = m_cnt;
          m_sum = p1.de ? gray_of(p1.pix) : 0;
          m_cnt = p1.de ? 1 : 0;
          m_upd = 2;
        end else if (p1.de) begin
          m_sum += gray_of(p1.pix);
          m_cnt++;
        end
        m_prev_vs = s.vs;
        hist.push_back(s);
      end
    end
  end

  initial begin
    forever begin
      @(negedge pix_clk);
      if (model_on) begin
        checks++;
        if ({vs_out, hs_out, de_out} !== {exp_vs, exp_hs, exp_de} ||
            pixel_data !== exp_pix || thresh_out !== 8'(m_thr)) begin
          errors++;
          if (fail_prints < 30) begin
            fail_prints++;
            $display("FAIL stream t=%0t got vs/hs/de=%b%b%b pix=%h thr=%0d required %b%b%b pix=%h thr=%0d",
                     $time, vs_out, hs_out, de_out, pixel_data, thresh_out,
                     exp_vs, exp_hs, exp_de, exp_pix, m_thr);
          end
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge pix_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, want);
    end
  endtask

  task automatic vsync(input int want_thr, input bit do_check);
    vs_in = 1'b1;
    tick();
    tick();
    vs_in = 1'b0;
    tick();
    if (do_check) chk("vsync_thr", 32'(thresh_out), 32'(want_thr));
    tick(); tick(); tick();
  endtask

  task automatic send_pix(input string name, input logic [23:0] p, input logic [23:0] want);
    pixel_in = p;
    de_in = 1'b1;
    tick();
    de_in = 1'b0;
    pixel_in = '0;
    tick();
    tick();
    chk(name, 32'(pixel_data), 32'(want));
    tick();
  endtask

  task automatic frame_body(input logic [23:0] p, input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (i != 0 && (i % H_ACT) == 0) begin
        de_in = 1'b0;
        hs_in = 1'b1;
        tick(); tick();
        hs_in = 1'b0;
        tick();
      end
      pixel_in = rnd ? 24'($urandom) : p;
      de_in = 1'b1;
      tick();
    end
    de_in = 1'b0;
    pixel_in = '0;
    tick(); tick(); tick(); tick();
  endtask

  typedef struct packed {
    logic [23:0] pix;
    logic [7:0]  thr;
    logic        byp;
    logic        de;
    logic [23:0] want;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{24'h808080, 8'd128, 1'b0, 1'b1, 24'hFFFFFF};
    vecs[1]  = '{24'h7F7F7F, 8'd128, 1'b0, 1'b1, 24'h000000};
    vecs[2]  = '{24'hFF0000, 8'd64,  1'b0, 1'b1, 24'hFFFFFF};
    vecs[3]  = '{24'hFF0000, 8'd77,  1'b0, 1'b1, 24'h000000};
    vecs[4]  = '{24'hFF0000, 8'd76,  1'b0, 1'b1, 24'hFFFFFF};
    vecs[5]  = '{24'h123456, 8'd128, 1'b1, 1'b1, 24'h123456};
    vecs[6]  = '{24'h123456, 8'd128, 1'b1, 1'b0, 24'h000000};
    vecs[7]  = '{24'hFFFFFF, 8'd255, 1'b0, 1'b1, 24'hFFFFFF};
    vecs[8]  = '{24'h000000, 8'd0,   1'b0, 1'b1, 24'hFFFFFF};
    vecs[9]  = '{24'h010101, 8'd2,   1'b0, 1'b1, 24'h000000};
    vecs[10] = '{24'h808080, 8'd128, 1'b0, 1'b1, 24'hFFFFFF};

    // reset with random inputs
    rstn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vs_in = 1'($urandom); hs_in = 1'($urandom); de_in = 1'($urandom);
      pixel_in = 24'($urandom); bypass = 1'($urandom);
      thresh_in = 8'($urandom); thresh_mode = 1'($urandom);
      tick();
    end
    chk("reset_outputs", {4'd0, vs_out, hs_out, de_out, pixel_data}, 32'd0);
    chk("reset_thr", 32'(thresh_out), 32'd128);
    vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0; pixel_in = '0; bypass = 1'b0;
    thresh_mode = 1'b0; thresh_in = 8'd128;
    rstn = 1'b1;
    tick(); tick(); tick();

    // first-pixel latency and alignment
    pixel_in = 24'h808080; de_in = 1'b1; hs_in = 1'b1;
    tick();
    pixel_in = '0; de_in = 1'b0; hs_in = 1'b0;
    tick();
    chk("latency_early_de", 32'(de_out), 32'd0);
    tick();
    chk("latency_de", 32'(de_out), 32'd1);
    chk("latency_hs", 32'(hs_out), 32'd1);
    chk("latency_pix", 32'(pixel_data), 32'hFFFFFF);
    tick();
    chk("latency_de_end", 32'(de_out), 32'd0);

    // fixed-threshold vector table
    for (int i = 0; i < 11; i++) begin
      thresh_in = vecs[i].thr;
      vsync(int'(vecs[i].thr), 1'b1);
      bypass = vecs[i].byp;
      pixel_in = vecs[i].pix;
      de_in = vecs[i].de;
      tick();
      de_in = 1'b0;
      pixel_in = '0;
      tick();
      tick();
      chk($sformatf("vec%0d_pix", i), 32'(pixel_data), 32'(vecs[i].want));
      chk($sformatf("vec%0d_de", i), 32'(de_out), 32'(vecs[i].de));
      tick();
      bypass = 1'b0;
    end

    // adaptive: full frame of gray 200
    thresh_mode = 1'b1;
    tick();
    vsync(128, 1'b1);
    frame_body(24'hC8C8C8, NPIX, 1'b0);
    vsync(200, 1'b1);
    send_pix("adapt_below", 24'hC7C7C7, 24'h000000);
    send_pix("adapt_equal", 24'hC8C8C8, 24'hFFFFFF);
    vsync(200, 1'b1);
    frame_body(24'h323232, NPIX + 1, 1'b0);
    vsync(200, 1'b1);

    // adaptive: reset mid-frame leaves a partial frame
    frame_body(24'h323232, 40, 1'b0);
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    chk("midreset_thr", 32'(thresh_out), 32'd128);
    frame_body(24'h323232, 40, 1'b0);
    vsync(128, 1'b1);
    frame_body(24'h323232, NPIX, 1'b0);
    vsync(50, 1'b1);

    // adaptive with random frames (model tracks the mean)
    for (int f = 0; f < 3; f++) begin
      frame_body(24'h0, NPIX, 1'b1);
      vsync(0, 1'b0);
    end

    // fixed mode: mid-frame thresh_in change waits for the next edge
    thresh_mode = 1'b0;
    thresh_in = 8'd128;
    tick();
    vsync(128, 1'b1);
    thresh_in = 8'd10;
    tick(); tick();
    chk("midframe_thr_held", 32'(thresh_out), 32'd128);
    send_pix("midframe_old", 24'h646464, 24'h000000);
    vsync(10, 1'b1);
    send_pix("midframe_new", 24'h646464, 24'hFFFFFF);

    // random stream, occasional resets, mode and threshold changes
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) vs_in = ~vs_in;
      hs_in = ($urandom_range(0, 7) == 0);
      de_in = 1'($urandom);
      pixel_in = 24'($urandom);
      bypass = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) thresh_mode = ~thresh_mode;
      if ($urandom_range(0, 49) == 0) thresh_in = 8'($urandom);
      rstn = ($urandom_range(0, 199) != 0);
      tick();
    end
    rstn = 1'b1;
    vs_in = 1'b0; de_in = 1'b0; hs_in = 1'b0;
    tick(); tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
